regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the pipelined core, the successor to the single-write, two-read register file. It provides NUM_RD combinational read ports, two prioritised write ports (ALU writeback and load writeback), an optional write-to-read bypass, and a per-register busy scoreboard. The decode stage uses the scoreboard for hazard detection. It sits between decode (reads, issue) and writeback (writes, clear), and also drives a debug read port for the testbench.

---
 rtl/regfile_mp_if.sv | 48 ++++
 rtl/regfile_mp.sv | 97 +++++++++
 tb/tb_regfile_mp.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register file bus: read ports, two write ports with busy-clear, issue
// marking and a debug read port. Decode/writeback drive the master side,
// the register file is the slave.
interface regfile_mp_if #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;

  logic                   wr0_en;
  logic [AW-1:0]          wr0_addr;
  logic [XLEN-1:0]        wr0_data;
  logic                   wr0_clr;

  logic                   wr1_en;
  logic [AW-1:0]          wr1_addr;
  logic [XLEN-1:0]        wr1_data;
  logic                   wr1_clr;

  logic                   iss_en;
  logic [AW-1:0]          iss_addr;

  logic [AW-1:0]          dbg_addr;
  logic [XLEN-1:0]        dbg_data;

  modport master (
    output rd_addr,
    output wr0_en, wr0_addr, wr0_data, wr0_clr,
    output wr1_en, wr1_addr, wr1_data, wr1_clr,
    output iss_en, iss_addr,
    output dbg_addr,
    input  rd_data, rd_busy, dbg_data
  );

  modport slave (
    input  rd_addr,
    input  wr0_en, wr0_addr, wr0_data, wr0_clr,
    input  wr1_en, wr1_addr, wr1_data, wr1_clr,
    input  iss_en, iss_addr,
    input  dbg_addr,
    output rd_data, rd_busy, dbg_data
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with two prioritised write ports
// (load port beats ALU port), optional write-to-read bypass and a per-register
// busy scoreboard used by decode for hazard detection. Register 0 is
// hardwired to zero and never busy.
module regfile_mp #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;

  logic [NUM_RD*XLEN-1:0] rdDataAll;
  logic [NUM_RD-1:0]      rdBusyAll;

  // Next-state of the array and scoreboard: wr1 is applied after wr0 so it
  // wins on an address collision; issue is applied after clears so a new
  // producer supersedes the one that is retiring; x0 is pinned to zero.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (bus.wr0_en) begin
      regs_d[bus.wr0_addr] = bus.wr0_data;
    end
    if (bus.wr1_en) begin
      regs_d[bus.wr1_addr] = bus.wr1_data;
    end
    if (bus.wr0_en && bus.wr0_clr) begin
      busy_d[bus.wr0_addr] = 1'b0;
    end
    if (bus.wr1_en && bus.wr1_clr) begin
      busy_d[bus.wr1_addr] = 1'b0;
    end
    if (bus.iss_en) begin
      busy_d[bus.iss_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // State update; reset wipes registers and scoreboard and drops any
  // write, clear or issue presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Combinational read ports: registered state, optionally overridden by a
  // same-cycle write (wr1 first); bypass is held off while reset is high.
  always_comb begin
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;
    rdDataAll = '0;
    rdBusyAll = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      addr = bus.rd_addr[k*AW +: AW];
      data = regs_q[addr];
      busy = busy_q[addr];
      if (BYPASS != 0 && !rst) begin
        if (bus.wr1_en && bus.wr1_addr == addr) begin
          data = bus.wr1_data;
          if (bus.wr1_clr) begin
            busy = bus.iss_en && (bus.iss_addr == addr);
          end
        end else if (bus.wr0_en && bus.wr0_addr == addr) begin
          data = bus.wr0_data;
          if (bus.wr0_clr) begin
            busy = bus.iss_en && (bus.iss_addr == addr);
          end
        end
      end
      if (addr == '0) begin
        data = '0;
        busy = 1'b0;
      end
      rdDataAll[k*XLEN +: XLEN] = data;
      rdBusyAll[k]              = busy;
    end
  end

  assign bus.rd_data  = rdDataAll;
  assign bus.rd_busy  = rdBusyAll;
  assign bus.dbg_data = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Three instances share one clock and reset:
// A (64b/32 regs/2 ports, bypass on), B (same, bypass off, same stimulus as A)
// and C (32b/16 regs/3 ports, bypass on). Stimulus pushes expected values
// into a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(64), .NREGS(32), .NUM_RD(2)) ifA ();
  regfile_mp_if #(.XLEN(64), .NREGS(32), .NUM_RD(2)) ifB ();
  regfile_mp_if #(.XLEN(32), .NREGS(16), .NUM_RD(3)) ifC ();

  regfile_mp #(.XLEN(64), .NREGS(32), .NUM_RD(2), .BYPASS(1)) dutA (
    .clk(clk), .rst(rst), .bus(ifA.slave));
  regfile_mp #(.XLEN(64), .NREGS(32), .NUM_RD(2), .BYPASS(0)) dutB (
    .clk(clk), .rst(rst), .bus(ifB.slave));
  regfile_mp #(.XLEN(32), .NREGS(16), .NUM_RD(3), .BYPASS(1)) dutC (
    .clk(clk), .rst(rst), .bus(ifC.slave));

  // kind: 0 = rd_data, 1 = rd_busy, 2 = dbg_data
  typedef struct {
    int          dut;
    int          kind;
    int          port;
    logic [63:0] value;
    string       tag;
  } expT;

  expT sb[$];
  int  vectors     = 0;
  int  miscompares = 0;

  function automatic logic [63:0] actualOf(input int dut, input int kind, input int port);
    logic [63:0] r;
    r = '0;
    case (dut)
      0: case (kind)
           0:       r = ifA.rd_data[port*64 +: 64];
           1:       r = {63'b0, ifA.rd_busy[port]};
           default: r = ifA.dbg_data;
         endcase
      1: case (kind)
           0:       r = ifB.rd_data[port*64 +: 64];
           1:       r = {63'b0, ifB.rd_busy[port]};
           default: r = ifB.dbg_data;
         endcase
      default: case (kind)
           0:       r = {32'b0, ifC.rd_data[port*32 +: 32]};
           1:       r = {63'b0, ifC.rd_busy[port]};
           default: r = {32'b0, ifC.dbg_data};
         endcase
    endcase
    return r;
  endfunction

  task automatic checkOutput(input expT e);
    logic [63:0] act;
    act = actualOf(e.dut, e.kind, e.port);
    vectors++;
    if (act !== e.value) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.tag, act, e.value);
    end
  endtask

  // Monitor: outputs are combinational, so every entry queued for the
  // current cycle is compared on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  task automatic push(input int dut, input int kind, input int port,
                      input logic [63:0] value, input string tag);
    expT e;
    e.dut   = dut;
    e.kind  = kind;
    e.port  = port;
    e.value = value;
    e.tag   = $sformatf("%s/%s", (dut == 0) ? "A" : (dut == 1) ? "B" : "C", tag);
    sb.push_back(e);
  endtask

  task automatic expAB(input int kind, input int port, input logic [63:0] valA,
                       input logic [63:0] valB, input string tag);
    push(0, kind, port, valA, tag);
    push(1, kind, port, valB, tag);
  endtask

  // Move to the next cycle and idle all enables on every instance.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    ifA.wr0_en = 1'b0; ifA.wr1_en = 1'b0; ifA.iss_en = 1'b0;
    ifA.wr0_clr = 1'b0; ifA.wr1_clr = 1'b0;
    ifB.wr0_en = 1'b0; ifB.wr1_en = 1'b0; ifB.iss_en = 1'b0;
    ifB.wr0_clr = 1'b0; ifB.wr1_clr = 1'b0;
    ifC.wr0_en = 1'b0; ifC.wr1_en = 1'b0; ifC.iss_en = 1'b0;
    ifC.wr0_clr = 1'b0; ifC.wr1_clr = 1'b0;
  endtask

  task automatic setWr0(input logic [4:0] a, input logic [63:0] d, input logic clr);
    ifA.wr0_en = 1'b1; ifA.wr0_addr = a; ifA.wr0_data = d; ifA.wr0_clr = clr;
    ifB.wr0_en = 1'b1; ifB.wr0_addr = a; ifB.wr0_data = d; ifB.wr0_clr = clr;
  endtask

  task automatic setWr1(input logic [4:0] a, input logic [63:0] d, input logic clr);
    ifA.wr1_en = 1'b1; ifA.wr1_addr = a; ifA.wr1_data = d; ifA.wr1_clr = clr;
    ifB.wr1_en = 1'b1; ifB.wr1_addr = a; ifB.wr1_data = d; ifB.wr1_clr = clr;
  endtask

  task automatic setIss(input logic [4:0] a);
    ifA.iss_en = 1'b1; ifA.iss_addr = a;
    ifB.iss_en = 1'b1; ifB.iss_addr = a;
  endtask

  task automatic setRd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] dbg);
    ifA.rd_addr = {a1, a0}; ifA.dbg_addr = dbg;
    ifB.rd_addr = {a1, a0}; ifB.dbg_addr = dbg;
  endtask

  task automatic setRdC(input logic [3:0] a0, input logic [3:0] a1,
                        input logic [3:0] a2, input logic [3:0] dbg);
    ifC.rd_addr  = {a2, a1, a0};
    ifC.dbg_addr = dbg;
  endtask

  // Directed sequence; comments give the hand-derived expectations.
  initial begin
    setRd(5'd0, 5'd0, 5'd0);
    setRdC(4'd0, 4'd0, 4'd0, 4'd0);
    ifA.wr0_addr = '0; ifA.wr0_data = '0; ifA.wr1_addr = '0; ifA.wr1_data = '0; ifA.iss_addr = '0;
    ifB.wr0_addr = '0; ifB.wr0_data = '0; ifB.wr1_addr = '0; ifB.wr1_data = '0; ifB.iss_addr = '0;
    ifC.wr0_addr = '0; ifC.wr0_data = '0; ifC.wr1_addr = '0; ifC.wr1_data = '0; ifC.iss_addr = '0;
    applyStimulus();
    rst = 1'b0;

    // Preload x5 = 0xAA and mark it busy; A bypasses data, busy not yet set
    setWr0(5'd5, 64'hAA, 1'b0);
    setIss(5'd5);
    setRd(5'd5, 5'd0, 5'd0);
    expAB(0, 0, 64'hAA, 64'h0, "preload bypass data");
    expAB(1, 0, 64'h0, 64'h0, "preload issue not yet visible");
    expAB(0, 1, 64'h0, 64'h0, "x0 read");

    applyStimulus();
    setRd(5'd5, 5'd0, 5'd5);
    expAB(0, 0, 64'hAA, 64'hAA, "preloaded x5");
    expAB(1, 0, 64'h1, 64'h1, "x5 busy after issue");
    expAB(2, 0, 64'hAA, 64'hAA, "dbg x5");

    // Reset cycle: write/issue ignored, bypass suppressed
    applyStimulus();
    rst = 1'b1;
    setWr1(5'd5, 64'h55, 1'b1);
    setIss(5'd6);
    setRd(5'd5, 5'd6, 5'd5);
    expAB(0, 0, 64'hAA, 64'hAA, "bypass held off in reset");
    expAB(1, 0, 64'h1, 64'h1, "busy shown registered in reset");

    applyStimulus();
    rst = 1'b0;
    setRd(5'd5, 5'd6, 5'd5);
    expAB(0, 0, 64'h0, 64'h0, "x5 cleared by reset");
    expAB(1, 0, 64'h0, 64'h0, "x5 busy cleared by reset");
    expAB(1, 1, 64'h0, 64'h0, "issue during reset dropped");
    expAB(2, 0, 64'h0, 64'h0, "dbg x5 after reset");

    // Dual write to x7: wr1 wins
    applyStimulus();
    setWr0(5'd7, 64'h1111, 1'b0);
    setWr1(5'd7, 64'h2222, 1'b0);
    setRd(5'd7, 5'd0, 5'd31);
    expAB(0, 0, 64'h2222, 64'h0, "x7 collision bypass");
    expAB(2, 0, 64'h0, 64'h0, "dbg x31 after reset");

    // Different addresses both land
    applyStimulus();
    setWr0(5'd3, 64'h3, 1'b0);
    setWr1(5'd4, 64'h4, 1'b0);
    setRd(5'd7, 5'd3, 5'd7);
    expAB(0, 0, 64'h2222, 64'h2222, "x7 collision result");
    expAB(0, 1, 64'h3, 64'h0, "x3 bypass");
    expAB(2, 0, 64'h2222, 64'h2222, "dbg x7");

    applyStimulus();
    setWr1(5'd9, 64'hBEEF, 1'b0);
    setRd(5'd3, 5'd4, 5'd0);
    expAB(0, 0, 64'h3, 64'h3, "x3 written");
    expAB(0, 1, 64'h4, 64'h4, "x4 written");

    // Bypass on x9 over old value 0xBEEF
    applyStimulus();
    setWr0(5'd9, 64'hDEAD, 1'b0);
    setRd(5'd9, 5'd0, 5'd9);
    expAB(0, 0, 64'hDEAD, 64'hBEEF, "x9 write-through");
    expAB(2, 0, 64'hBEEF, 64'hBEEF, "dbg never bypassed");

    applyStimulus();
    setRd(5'd9, 5'd0, 5'd0);
    expAB(0, 0, 64'hDEAD, 64'hDEAD, "x9 after write");

    // Scoreboard: issue x12 in cycle 0, clear with wr1 in cycle 3
    applyStimulus();
    setIss(5'd12);
    setRd(5'd12, 5'd0, 5'd0);
    expAB(1, 0, 64'h0, 64'h0, "issue cycle0 busy");

    applyStimulus();
    setRd(5'd12, 5'd0, 5'd0);
    expAB(1, 0, 64'h1, 64'h1, "issue cycle1 busy");

    applyStimulus();
    setRd(5'd0, 5'd12, 5'd0);
    expAB(1, 1, 64'h1, 64'h1, "issue cycle2 busy port1");

    applyStimulus();
    setWr1(5'd12, 64'h1234, 1'b1);
    setRd(5'd12, 5'd0, 5'd0);
    expAB(1, 0, 64'h0, 64'h1, "clear cycle3 busy");
    expAB(0, 0, 64'h1234, 64'h0, "clear cycle3 data");

    applyStimulus();
    setRd(5'd12, 5'd0, 5'd0);
    expAB(1, 0, 64'h0, 64'h0, "clear cycle4 busy");
    expAB(0, 0, 64'h1234, 64'h1234, "clear cycle4 data");

    // Issue and clear to x12 together: issue wins, data still written
    applyStimulus();
    setIss(5'd12);
    setWr0(5'd12, 64'h5678, 1'b1);
    setRd(5'd12, 5'd0, 5'd0);
    expAB(1, 0, 64'h1, 64'h0, "issue+clear same cycle busy");
    expAB(0, 0, 64'h5678, 64'h1234, "issue+clear same cycle data");

    applyStimulus();
    setRd(5'd12, 5'd0, 5'd12);
    expAB(1, 0, 64'h1, 64'h1, "issue beats clear");
    expAB(0, 0, 64'h5678, 64'h5678, "x12 holds wr0 data");
    expAB(2, 0, 64'h5678, 64'h5678, "dbg x12");

    // x0 ignores writes and issues
    applyStimulus();
    setWr0(5'd0, 64'hFF, 1'b0);
    setIss(5'd0);
    setRd(5'd0, 5'd0, 5'd0);
    expAB(0, 0, 64'h0, 64'h0, "x0 write bypass");
    expAB(1, 0, 64'h0, 64'h0, "x0 issue busy");

    applyStimulus();
    setRd(5'd0, 5'd12, 5'd0);
    expAB(0, 0, 64'h0, 64'h0, "x0 after write");
    expAB(1, 0, 64'h0, 64'h0, "x0 after issue");
    expAB(2, 0, 64'h0, 64'h0, "dbg x0");
    expAB(0, 1, 64'h5678, 64'h5678, "port1 independent");

    // Small configuration: 32-bit, 16 registers, three read ports
    applyStimulus();
    ifC.wr0_en = 1'b1; ifC.wr0_addr = 4'd7; ifC.wr0_data = 32'h1111;
    ifC.wr1_en = 1'b1; ifC.wr1_addr = 4'd7; ifC.wr1_data = 32'h2222;
    ifC.iss_en = 1'b1; ifC.iss_addr = 4'd5;
    setRdC(4'd7, 4'd5, 4'd0, 4'd0);
    push(2, 0, 0, 64'h2222, "x7 collision bypass p0");
    push(2, 1, 1, 64'h0, "x5 issue not yet visible p1");
    push(2, 0, 2, 64'h0, "x0 p2");

    applyStimulus();
    ifC.wr0_en = 1'b1; ifC.wr0_addr = 4'd3;  ifC.wr0_data = 32'h33;
    ifC.wr1_en = 1'b1; ifC.wr1_addr = 4'd15; ifC.wr1_data = 32'hF00D;
    setRdC(4'd7, 4'd5, 4'd15, 4'd7);
    push(2, 0, 0, 64'h2222, "x7 result p0");
    push(2, 1, 1, 64'h1, "x5 busy p1");
    push(2, 0, 2, 64'hF00D, "x15 bypass p2");
    push(2, 1, 2, 64'h0, "x15 not busy p2");
    push(2, 2, 0, 64'h2222, "dbg x7");

    applyStimulus();
    ifC.wr0_en = 1'b1; ifC.wr0_addr = 4'd5; ifC.wr0_data = 32'hCAFE; ifC.wr0_clr = 1'b1;
    setRdC(4'd3, 4'd5, 4'd15, 4'd15);
    push(2, 0, 0, 64'h33, "x3 p0");
    push(2, 0, 1, 64'hCAFE, "x5 bypass p1");
    push(2, 1, 1, 64'h0, "x5 bypassed clear p1");
    push(2, 0, 2, 64'hF00D, "x15 p2");
    push(2, 2, 0, 64'hF00D, "dbg x15");

    applyStimulus();
    ifC.wr0_en = 1'b1; ifC.wr0_addr = 4'd0; ifC.wr0_data = 32'hFF;
    ifC.iss_en = 1'b1; ifC.iss_addr = 4'd0;
    setRdC(4'd0, 4'd5, 4'd7, 4'd5);
    push(2, 0, 0, 64'h0, "x0 write p0");
    push(2, 1, 0, 64'h0, "x0 issue p0");
    push(2, 0, 1, 64'hCAFE, "x5 p1");
    push(2, 1, 1, 64'h0, "x5 cleared p1");
    push(2, 0, 2, 64'h2222, "x7 p2");
    push(2, 2, 0, 64'hCAFE, "dbg x5");

    applyStimulus();
    setRdC(4'd0, 4'd0, 4'd0, 4'd0);
    push(2, 0, 0, 64'h0, "x0 after write p0");
    push(2, 1, 0, 64'h0, "x0 after issue p0");

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
